// File: rtl/spi_reg_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_master
//  Description : Host-side controller for the 24-bit SPI register-slave frame
//                protocol. Takes one register read/write per request, sends
//                one frame per write and two frames per read (read + NOP),
//                and returns the read byte on o_rdata.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_master #(
    parameter int CLK_DIV = 4,  // SCK half-period in i_clk cycles (>= 2)
    parameter int CS_GAP  = 2   // minimum CS-high cycles between transactions (>= 1)
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_req,
    input  logic       i_we,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_ready,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_cs,
    output logic       o_sck,
    output logic       o_copi,
    input  logic       i_cipo
);

    // One counter serves both the SCK phase divider and the CS gap timer.
    localparam int c_CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(CS_GAP - 1);

    localparam logic [7:0] c_CMD_READ  = 8'h01;
    localparam logic [7:0] c_CMD_WRITE = 8'h02;

    localparam logic [4:0] c_LAST_BIT = 5'd23;
    localparam logic [4:0] c_RD_FIRST = 5'd15;
    localparam logic [4:0] c_RD_LAST  = 5'd22;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SETUP = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_HOLD  = 3'd3;
    localparam logic [2:0] c_ST_GAP   = 3'd4;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_bit;     // index of the frame bit currently on o_copi
    logic               r_frame2;  // second (NOP) frame of a read
    logic               r_last;    // final bit shifted, trailing SCK-low phase
    logic               r_we;
    logic [7:0]         r_addr;
    logic [7:0]         r_wdata;
    logic               r_ready;
    logic               r_done;
    logic [7:0]         r_rdata;
    logic               r_cs;
    logic               r_sck;
    logic               r_copi;

    logic [23:0] w_frame;
    logic [4:0]  w_bit_nx;
    logic        w_next_copi;
    logic [2:0]  w_rd_idx;
    logic        w_rd_win;
    logic        w_div_end;

    // Frame image, LSB-first per field: cmd in b0-7, addr in b8-15, data in b16-23.
    assign w_frame     = {(r_we ? r_wdata : 8'h00), r_addr, (r_we ? c_CMD_WRITE : c_CMD_READ)};
    assign w_bit_nx    = r_bit + 5'd1;
    // The NOP frame of a read is all zeros.
    assign w_next_copi = (!r_frame2 && (r_bit != c_LAST_BIT)) ? w_frame[w_bit_nx] : 1'b0;
    // Bits 15..22 of the NOP frame carry read-data bits 0..7; (b - 15) mod 8 == (b + 1) mod 8.
    assign w_rd_idx    = r_bit[2:0] + 3'd1;
    assign w_rd_win    = r_frame2 && (r_bit >= c_RD_FIRST) && (r_bit <= c_RD_LAST);
    assign w_div_end   = (r_cnt == c_DIV_LAST);

    // Transaction sequencer: handshake, SCK generation, bit shifting and read capture.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_bit    <= 5'd0;
            r_frame2 <= 1'b0;
            r_last   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 8'h00;
            r_wdata  <= 8'h00;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_rdata  <= 8'h00;
            r_cs     <= 1'b1;
            r_sck    <= 1'b0;
            r_copi   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (i_req) begin
                        r_we     <= i_we;
                        r_addr   <= i_addr;
                        r_wdata  <= i_wdata;
                        r_ready  <= 1'b0;
                        r_cs     <= 1'b0;
                        // cmd bit 0 is 1 for read (0x01), 0 for write (0x02)
                        r_copi   <= ~i_we;
                        r_bit    <= 5'd0;
                        r_frame2 <= 1'b0;
                        r_last   <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= c_ST_SETUP;
                    end
                end

                c_ST_SETUP: begin
                    if (w_div_end) begin
                        r_cnt   <= '0;
                        r_sck   <= 1'b1;
                        r_state <= c_ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_SHIFT: begin
                    if (!w_div_end) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                        if (r_sck) begin
                            // Falling edge: capture read data, then present the next bit.
                            r_sck <= 1'b0;
                            if (w_rd_win) begin
                                r_rdata[w_rd_idx] <= i_cipo;
                            end
                            if (r_bit == c_LAST_BIT) begin
                                r_copi <= 1'b0;
                                if (!r_we && !r_frame2) begin
                                    // Read: roll straight into the NOP frame, CS stays low.
                                    r_frame2 <= 1'b1;
                                    r_bit    <= 5'd0;
                                end else begin
                                    r_last <= 1'b1;
                                end
                            end else begin
                                r_bit  <= w_bit_nx;
                                r_copi <= w_next_copi;
                            end
                        end else if (r_last) begin
                            r_last  <= 1'b0;
                            r_state <= c_ST_HOLD;
                        end else begin
                            r_sck <= 1'b1;
                        end
                    end
                end

                c_ST_HOLD: begin
                    if (w_div_end) begin
                        r_cnt   <= '0;
                        r_cs    <= 1'b1;
                        r_copi  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    r_cs    <= 1'b1;
                    r_sck   <= 1'b0;
                    r_copi  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_done  = r_done;
    assign o_rdata = r_rdata;
    assign o_cs    = r_cs;
    assign o_sck   = r_sck;
    assign o_copi  = r_copi;

endmodule
`default_nettype wire
